// File: rtl/seven_seg_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver_pkg
// Shared definitions for the seven-segment scan driver (the "seven_seg_defs"
// header): special digit codes, the sixteen active-low segment patterns
// ({g,f,e,d,c,b,a}), the scan slot encoding and the packed digit record.
// No ports; imported by the interface, decoder and top.
// ---------------------------------------------------------------------------
package seven_seg_scan_driver_pkg;

  // Digit codes with special meaning above the hex range that is shown literally
  localparam logic [3:0] CODE_BLANK = 4'd14;
  localparam logic [3:0] CODE_MINUS = 4'd15;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Scan slot index; slot n drives an[n]
  typedef enum logic [1:0] {
    SLOT_ONE  = 2'd0,
    SLOT_TEN  = 2'd1,
    SLOT_HUN  = 2'd2,
    SLOT_SIGN = 2'd3
  } slot_e;

  // One full set of display digits
  typedef struct packed {
    logic [3:0] sign;
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
  } digits_t;

  localparam digits_t DIGITS_BLANK = digits_t'({4{CODE_BLANK}});

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver_if
// Bundles the digit-code capture bus from the BCD encoder and the display
// pins going to the board.
//   sign/hun/ten/one : 4-bit digit codes (sign: 14 blank, 15 minus)
//   data_valid       : capture strobe for the four codes
//   an               : active-low digit enables, an[0] = ones .. an[3] = sign
//   seg              : active-low segments {g,f,e,d,c,b,a}
//   frame_strobe     : one-cycle pulse at each frame commit
// master = producer / observer side, slave = the scan driver itself.
// ---------------------------------------------------------------------------
interface seven_seg_scan_driver_if;

  logic [3:0] sign;
  logic [3:0] hun;
  logic [3:0] ten;
  logic [3:0] one;
  logic       data_valid;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_strobe;

  modport master (
    output sign, hun, ten, one, data_valid,
    input  an, seg, frame_strobe
  );

  modport slave (
    input  sign, hun, ten, one, data_valid,
    output an, seg, frame_strobe
  );

endinterface

// File: rtl/seven_seg_scan_driver_decoder.sv
// ---------------------------------------------------------------------------
// seven_seg_decoder
// Purely combinational 4-bit digit code to active-low seven-segment pattern.
//   code : digit code 0..15 (10..13 = A,b,C,d; 14 = blank; 15 = minus)
//   seg  : pattern {g,f,e,d,c,b,a}, low = segment lit
// ---------------------------------------------------------------------------
module seven_seg_decoder
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Full 16-entry table, so every code has a defined pattern
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd10:   seg = SEG_A;
      4'd11:   seg = SEG_B;
      4'd12:   seg = SEG_C;
      4'd13:   seg = SEG_D;
      4'd14:   seg = SEG_BLANK;
      default: seg = SEG_MINUS;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexes four digit codes onto a 4-digit common-anode display.
// A refresh divider produces one tick per digit slot, a 2-bit scan index
// walks ones -> ten -> hun -> sign, and a double-buffered digit store
// (pending + display) means shown values only change at frame end.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : seven_seg_scan_driver_if.slave (codes, data_valid, an, seg,
//              frame_strobe)
// Parameter CLK_DIV (>= 2): clock cycles per digit slot.
// Build option: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading
// zeros in the hundreds and tens slots at decode time.
// ---------------------------------------------------------------------------
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  seven_seg_scan_driver_if.slave bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  slot_e            idx_q, idx_d;
  digits_t          pend_q, pend_d;
  digits_t          disp_q, disp_d;
  logic             dirty_q, dirty_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             tick;
  logic             commit;
  logic [3:0]       slot_code;
  logic [3:0]       shown_code;
  logic [6:0]       dec_seg;

  // Divider, scan index and double-buffered digit store. A capture in the
  // commit cycle still moves the old pending set to the display and keeps
  // dirty set so the new set lands on the following frame.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    idx_d   = idx_q;
    pend_d  = pend_q;
    disp_d  = disp_q;
    dirty_d = dirty_q;

    tick   = (count_q == CNT_W'(CLK_DIV - 1));
    commit = tick && (idx_q == SLOT_SIGN);

    if (tick) begin
      count_d = '0;
      idx_d   = slot_e'(idx_q + 2'd1);
    end

    if (commit && dirty_q) begin
      disp_d  = pend_q;
      dirty_d = 1'b0;
    end

    if (bus.data_valid) begin
      pend_d  = '{sign: bus.sign, hun: bus.hun, ten: bus.ten, one: bus.one};
      dirty_d = 1'b1;
    end
  end

  // Select the display digit for the current slot, then optionally blank
  // leading zeros (ones and sign are never touched)
  always_comb begin
    slot_code = disp_q.one;
    case (idx_q)
      SLOT_ONE:  slot_code = disp_q.one;
      SLOT_TEN:  slot_code = disp_q.ten;
      SLOT_HUN:  slot_code = disp_q.hun;
      SLOT_SIGN: slot_code = disp_q.sign;
      default:   slot_code = disp_q.one;
    endcase

    shown_code = slot_code;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if ((idx_q == SLOT_HUN) && (disp_q.hun == 4'd0)) begin
      shown_code = CODE_BLANK;
    end
    if ((idx_q == SLOT_TEN) && (disp_q.ten == 4'd0) && (disp_q.hun == 4'd0)) begin
      shown_code = CODE_BLANK;
    end
`else
    shown_code = slot_code;
`endif
  end

  seven_seg_decoder u_decoder (
    .code (shown_code),
    .seg  (dec_seg)
  );

  // Registered pin drive follows the scan index by one cycle
  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = dec_seg;
  end

  // State register with synchronous reset; reset blanks every digit and
  // discards pending data
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      idx_q   <= SLOT_ONE;
      pend_q  <= DIGITS_BLANK;
      disp_q  <= DIGITS_BLANK;
      dirty_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      count_q <= count_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      dirty_q <= dirty_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.an           = an_q;
  assign bus.seg          = seg_q;
  assign bus.frame_strobe = commit;

endmodule
